paddle_ctrl: RTL and testbench

PADDLE_CTRL -- requirements
Module: paddle_ctrl

---
 rtl/pong_pkg.sv | 34 +++
 rtl/key_filter.sv | 70 +++++++
 rtl/paddle_ctrl.sv | 85 ++++++++
 tb/tb_paddle_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong paddle controller.
// Filter state encodings, default screen geometry, paddle step helper.
package pong_pkg;

    typedef enum logic [1:0] {
        ZERO = 2'b00,
        ZTO  = 2'b01,
        ONE  = 2'b10,
        OTZ  = 2'b11
    } filt_state_t;

    localparam int DEF_Y_MAX = 480;
    localparam int DEF_PAD_H = 80;

    // Saturating move in 11 bits so neither 0 nor lim is ever crossed.
    function automatic logic [9:0] step_y(
        input logic [9:0] y,
        input logic       up,
        input logic       dn,
        input int         step,
        input int         lim
    );
        logic [10:0] w_sum;
        step_y = y;
        if (up && !dn) begin
            w_sum  = {1'b0, y} - 11'(step);
            step_y = w_sum[10] ? 10'd0 : w_sum[9:0];
        end else if (dn && !up) begin
            w_sum  = {1'b0, y} + 11'(step);
            step_y = (w_sum > 11'(lim)) ? 10'(lim) : w_sum[9:0];
        end
    endfunction

endpackage

// File: rtl/key_filter.sv
// Four-state debounce filter for one raw key.
// The clean level flips only after the raw level is stable long enough.
module key_filter
    import pong_pkg::*;
#(
    parameter int DEB_CYCLES = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic keyin,
    output logic keyout
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    filt_state_t   r_state;
    filt_state_t   w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ONE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        unique case (r_state)
            ZERO: begin
                if (keyin) begin
                    w_next     = ZTO;
                    w_cnt_next = '0;
                end
            end
            ZTO: begin
                if (!keyin)
                    w_next = ZERO;
                else if (r_cnt == LAST)
                    w_next = ONE;
                else
                    w_cnt_next = r_cnt + 1'b1;
            end
            ONE: begin
                if (!keyin) begin
                    w_next     = OTZ;
                    w_cnt_next = '0;
                end
            end
            OTZ: begin
                if (keyin)
                    w_next = ONE;
                else if (r_cnt == LAST)
                    w_next = ZERO;
                else
                    w_cnt_next = r_cnt + 1'b1;
            end
            default: w_next = ONE;
        endcase
    end

    assign keyout = (r_state == ONE) || (r_state == OTZ);

endmodule

// File: rtl/paddle_ctrl.sv
// Two-paddle controller: debounced keys, press pulses,
// shared movement tick and saturating paddle positions.
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int DEB_CYCLES = 5000000,
    parameter int MOVE_DIV   = 250000,
    parameter int STEP       = 4,
    parameter int Y_MAX      = DEF_Y_MAX,
    parameter int PAD_H      = DEF_PAD_H,
    parameter int Y_INIT     = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] key_up,
    input  logic [1:0] key_dn,
    output logic [9:0] pad0_y,
    output logic [9:0] pad1_y,
    output logic [3:0] key_evt
);

    localparam int Y_LIM = Y_MAX - PAD_H;
    localparam int TW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(MOVE_DIV - 1);

    logic [3:0]    w_raw;
    logic [3:0]    w_clean;
    logic [3:0]    r_prev;
    logic [3:0]    r_evt;
    logic [TW-1:0] r_tcnt;
    logic          w_tick;
    logic [9:0]    r_pad0;
    logic [9:0]    r_pad1;

    // Bit order matches key_evt: {dn1, up1, dn0, up0}.
    assign w_raw = {key_dn[1], key_up[1], key_dn[0], key_up[0]};

    for (genvar g = 0; g < 4; g++) begin : g_f
        key_filter #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_kf (
            .clk   (clk),
            .rst   (rst),
            .keyin (w_raw[g]),
            .keyout(w_clean[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= '1;
            r_evt  <= '0;
        end else begin
            r_prev <= w_clean;
            r_evt  <= w_clean & ~r_prev;
        end
    end

    assign w_tick = en && (r_tcnt == T_LAST);

    always_ff @(posedge clk) begin
        if (rst || !en || w_tick)
            r_tcnt <= '0;
        else
            r_tcnt <= r_tcnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pad0 <= 10'(Y_INIT);
            r_pad1 <= 10'(Y_INIT);
        end else if (w_tick) begin
            r_pad0 <= step_y(r_pad0, w_clean[0], w_clean[1],
                             STEP, Y_LIM);
            r_pad1 <= step_y(r_pad1, w_clean[2], w_clean[3],
                             STEP, Y_LIM);
        end
    end

    assign pad0_y  = r_pad0;
    assign pad1_y  = r_pad1;
    assign key_evt = r_evt;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Self-checking bench for paddle_ctrl with a cycle-level reference
// model feeding a scoreboard queue, plus directed endpoint checks.
module tb_paddle_ctrl;

    localparam int DEB  = 4;
    localparam int MD   = 3;
    localparam int STEP = 4;
    localparam int YI   = 200;
    localparam int YM   = 480;
    localparam int PH   = 80;
    localparam int LIM  = YM - PH;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] key_up;
    logic [1:0] key_dn;
    logic [9:0] pad0_y;
    logic [9:0] pad1_y;
    logic [3:0] key_evt;

    always #5 clk = ~clk;

    paddle_ctrl #(
        .DEB_CYCLES(DEB),
        .MOVE_DIV  (MD),
        .STEP      (STEP),
        .Y_MAX     (YM),
        .PAD_H     (PH),
        .Y_INIT    (YI)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .key_up (key_up),
        .key_dn (key_dn),
        .pad0_y (pad0_y),
        .pad1_y (pad1_y),
        .key_evt(key_evt)
    );

    typedef struct {
        logic [9:0] p0;
        logic [9:0] p1;
        logic [3:0] ev;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic [3:0] m_clean;
    logic [3:0] m_prev;
    logic [3:0] m_evt;
    int         m_run[4];
    int         m_tcnt;
    int         m_p0;
    int         m_p1;

    int evt_cnt[4];
    int p1_max;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int mv(input int y, input logic up,
                              input logic dn);
        if (up && !dn) return (y - STEP < 0) ? 0 : y - STEP;
        if (dn && !up) return (y + STEP > LIM) ? LIM : y + STEP;
        return y;
    endfunction

    // Clean level flips once raw has differed for DEB+1 sampled edges.
    task automatic model_edge();
        logic [3:0] raw;
        logic [3:0] nclean;
        bit         tick;
        raw = {key_dn[1], key_up[1], key_dn[0], key_up[0]};
        if (rst) begin
            m_clean = '1;
            m_prev  = '1;
            m_evt   = '0;
            m_tcnt  = 0;
            m_p0    = YI;
            m_p1    = YI;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            return;
        end
        tick   = en && (m_tcnt == MD - 1);
        m_evt  = m_clean & ~m_prev;
        m_prev = m_clean;
        nclean = m_clean;
        for (int i = 0; i < 4; i++) begin
            if (raw[i] != m_clean[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB + 1) begin
                    nclean[i] = raw[i];
                    m_run[i]  = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        if (tick) begin
            m_p0 = mv(m_p0, m_clean[0], m_clean[1]);
            m_p1 = mv(m_p1, m_clean[2], m_clean[3]);
        end
        m_clean = nclean;
        if (!en || tick) m_tcnt = 0;
        else             m_tcnt++;
    endtask

    task automatic cyc();
        exp_t e;
        model_edge();
        e.p0 = 10'(m_p0);
        e.p1 = 10'(m_p1);
        e.ev = m_evt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("pad0_y", 32'(pad0_y), 32'(e.p0));
        chk("pad1_y", 32'(pad1_y), 32'(e.p1));
        chk("key_evt", 32'(key_evt), 32'(e.ev));
        for (int i = 0; i < 4; i++)
            if (key_evt[i] === 1'b1) evt_cnt[i]++;
        if (pad1_y > p1_max) p1_max = int'(pad1_y);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic clr_evt();
        for (int i = 0; i < 4; i++) evt_cnt[i] = 0;
    endtask

    logic [3:0] clean_obs;
    assign clean_obs = {dut.g_f[3].u_kf.keyout, dut.g_f[2].u_kf.keyout,
                        dut.g_f[1].u_kf.keyout, dut.g_f[0].u_kf.keyout};

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        key_up = 2'b11;
        key_dn = 2'b11;
        p1_max = 0;
        clr_evt();
        run(2);
        chk("rst_pad0", 32'(pad0_y), 32'(YI));
        chk("rst_pad1", 32'(pad1_y), 32'(YI));
        chk("rst_evt", 32'(key_evt), 32'd0);
        chk("rst_clean", 32'(clean_obs), 32'hF);
        rst = 1'b0;
        run(3);

        // Bouncing up0, then held low: clean drops, no press pulse.
        for (int b = 0; b < 2; b++) begin
            key_up[0] = 1'b0;
            run(2);
            key_up[0] = 1'b1;
            run(2);
        end
        key_up[0] = 1'b0;
        run(4);
        chk("up0_still_high", 32'(clean_obs[0]), 32'd1);
        run(1);
        chk("up0_now_low", 32'(clean_obs[0]), 32'd0);
        run(5);
        chk("bounce_no_evt", 32'(evt_cnt[0]), 32'd0);

        // Hold dn0 low, release up0: one press pulse, then move up.
        key_dn[0] = 1'b0;
        run(8);
        clr_evt();
        key_up[0] = 1'b1;
        run(8);
        chk("up0_pulses", 32'(evt_cnt[0]), 32'd1);
        en = 1'b1;
        run(3);
        chk("pad0_first", 32'(pad0_y), 32'd196);
        run(3);
        chk("pad0_second", 32'(pad0_y), 32'd192);
        chk("pad1_hold", 32'(pad1_y), 32'(YI));

        // Freeze with en=0 while a dn0 release still pulses.
        en = 1'b0;
        clr_evt();
        key_dn[0] = 1'b1;
        run(9);
        chk("pad0_frozen", 32'(pad0_y), 32'd192);
        chk("dn0_pulses", 32'(evt_cnt[1]), 32'd1);
        en = 1'b1;
        run(9);
        chk("pad0_both_hold", 32'(pad0_y), 32'd192);

        // Paddle 1 down to the floor, then up to the top.
        key_up[1] = 1'b0;
        key_dn[1] = 1'b1;
        p1_max = 0;
        run(620);
        chk("pad1_floor", 32'(pad1_y), 32'(LIM));
        chk("pad1_max_dn", 32'(p1_max <= LIM), 32'd1);
        key_up[1] = 1'b1;
        key_dn[1] = 1'b0;
        run(620);
        chk("pad1_top", 32'(pad1_y), 32'd0);
        chk("pad1_max_up", 32'(p1_max <= LIM), 32'd1);
        chk("pad0_untouched", 32'(pad0_y), 32'd192);

        // Reset mid-debounce, in the same cycle as a tick.
        key_dn[0] = 1'b0;
        run(2);
        for (int i = 0; i < MD && m_tcnt != MD - 1; i++) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst2_pad0", 32'(pad0_y), 32'(YI));
        chk("rst2_pad1", 32'(pad1_y), 32'(YI));
        chk("rst2_evt", 32'(key_evt), 32'd0);
        chk("rst2_clean", 32'(clean_obs), 32'hF);
        cyc();
        chk("post_rst_evt", 32'(key_evt), 32'd0);
        run(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
